// File: rtl/ps2_keyboard_receiver.sv
// PS/2 keyboard frame receiver with make/break/E0 decode of the currently held key.
// Optional build macro PS2_PARITY_CHECK_EN enables rejection of frames with bad odd parity.
module ps2_keyboard_receiver #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] IO_to_mem_data,
  output logic       key_extended,
  output logic       key_valid,
  output logic       frame_error
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

  logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
  logic                   clk_prev_q, fe_q, bit_q;
  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   parity_q, parity_d;
  logic                   ext_q, ext_d, brk_q, brk_d;
  logic [7:0]             data_q, data_d;
  logic                   kext_q, kext_d, valid_q, valid_d, err_q, err_d;
  logic                   frame_end, timeout, frame_ok;

  // Synchronisers idle high so leaving reset never fabricates a falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
      fe_q        <= 1'b0;
      bit_q       <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
      clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
      fe_q        <= clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
      bit_q       <= data_sync_q[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
      data_q    <= 8'h00;
      kext_q    <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      ext_q     <= ext_d;
      brk_q     <= brk_d;
      data_q    <= data_d;
      kext_q    <= kext_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  // A falling edge always takes priority over an expiring timeout.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    frame_end = 1'b0;
    timeout   = 1'b0;
    if (fe_q) begin
      cnt_d = '0;
      case (state_q)
        IDLE: begin
          if (!bit_q) begin
            state_d   = DATA;
            bit_cnt_d = 3'd0;
          end
        end
        DATA: begin
          shift_d   = {bit_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          parity_d = bit_q;
          state_d  = STOP;
        end
        default: begin
          frame_end = 1'b1;
          state_d   = IDLE;
        end
      endcase
    end else if (state_q != IDLE) begin
      if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
        timeout = 1'b1;
        cnt_d   = '0;
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_comb begin
`ifdef PS2_PARITY_CHECK_EN
    frame_ok = bit_q & (^{parity_q, shift_q});
`else
    frame_ok = bit_q;
`endif
    data_d  = data_q;
    kext_d  = kext_q;
    ext_d   = ext_q;
    brk_d   = brk_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (timeout || (frame_end && !frame_ok)) begin
      err_d = 1'b1;
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (frame_end) begin
      if (shift_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (shift_q == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        if (!brk_q) begin
          data_d  = shift_q;
          kext_d  = ext_q;
          valid_d = 1'b1;
        end else if (shift_q == data_q && ext_q == kext_q) begin
          data_d = 8'h00;
          kext_d = 1'b0;
        end
      end
    end
  end

  assign IO_to_mem_data = data_q;
  assign key_extended   = kext_q;
  assign key_valid      = valid_q;
  assign frame_error    = err_q;
endmodule

// File: tb/tb_ps2_keyboard_receiver.sv
// Bench for ps2_keyboard_receiver: frame-level key model with scheduled expected outputs,
// compared every cycle, plus directed scenarios and a randomized key/corruption stream.
module tb_ps2_keyboard_receiver;
  localparam int T   = 64;
  localparam int LAT = 4;

  logic       clk = 1'b0, reset = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic [7:0] io;
  logic       kext, kvalid, ferr;

  ps2_keyboard_receiver #(.TIMEOUT_CYCLES(T), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .IO_to_mem_data(io), .key_extended(kext), .key_valid(kvalid), .frame_error(ferr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, passed = 0;
  int n_valid = 0, n_err = 0;
  bit checking = 1'b0;

  // logical key state after every frame sent so far
  logic [7:0] m_held = 8'h00;
  logic       m_kext = 1'b0, m_ext = 1'b0, m_brk = 1'b0;

  // expected outputs as visible on the pins
  logic [7:0] exp_data = 8'h00;
  logic       exp_ext = 1'b0, exp_valid = 1'b0, exp_err = 1'b0;

  // one scheduled output change; armed on the next pin fall
  int         ev_cyc = -1;
  logic [7:0] ev_data = 8'h00;
  logic       ev_ext = 1'b0, ev_valid = 1'b0, ev_err = 1'b0;
  bit         arm = 1'b0;
  int         arm_ofs = LAT;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    else passed++;
  endtask

  always @(posedge clk) begin
    #1;
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    if (cyc == ev_cyc) begin
      exp_data  = ev_data;
      exp_ext   = ev_ext;
      exp_valid = ev_valid;
      exp_err   = ev_err;
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("IO_to_mem_data", {24'd0, io}, {24'd0, exp_data});
      chk("key_extended", {31'd0, kext}, {31'd0, exp_ext});
      chk("key_valid", {31'd0, kvalid}, {31'd0, exp_valid});
      chk("frame_error", {31'd0, ferr}, {31'd0, exp_err});
      if (kvalid) n_valid++;
      if (ferr) n_err++;
    end
  end

  task automatic send_bit(input logic b, input int h);
    @(negedge clk);
    ps2_data = b;
    repeat (h) @(negedge clk);
    ps2_clk = 1'b0;
    if (arm) begin
      ev_cyc = cyc + arm_ofs;
      arm    = 1'b0;
    end
    repeat (h) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  // Frame-level decode rules; returns whether the visible outputs must change.
  function automatic bit model_frame(input logic [7:0] b, input bit ok);
    bit need = 1'b0;
    ev_valid = 1'b0;
    ev_err   = 1'b0;
    if (!ok) begin
      m_ext  = 1'b0;
      m_brk  = 1'b0;
      ev_err = 1'b1;
      need   = 1'b1;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      if (!m_brk) begin
        m_held   = b;
        m_kext   = m_ext;
        ev_valid = 1'b1;
        need     = 1'b1;
      end else if (b == m_held && m_ext == m_kext) begin
        m_held = 8'h00;
        m_kext = 1'b0;
        need   = 1'b1;
      end
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
    ev_data = m_held;
    ev_ext  = m_kext;
    return need;
  endfunction

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input logic stop, input int h);
    logic par;
    bit   ok, need;
    par = (~^b) ^ bad_par;
`ifdef PS2_PARITY_CHECK_EN
    ok = stop && !bad_par;
`else
    ok = stop;
`endif
    need = model_frame(b, ok);
    send_bit(1'b0, h);
    for (int i = 0; i < 8; i++) send_bit(b[i], h);
    send_bit(par, h);
    arm_ofs = LAT;
    arm     = need;
    send_bit(stop, h);
    repeat (LAT + 2) @(negedge clk);
    $display("frame %02h par_flip=%0d stop=%0d -> held %02h ext %0d", b, bad_par, stop, m_held, m_kext);
  endtask

  initial begin
    int vb, ve, h, r;
    logic [7:0] code;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset    = 1'b0;
    checking = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_data", {24'd0, io}, 32'h00);

    // 1: single make
    send_frame(8'h1C, 0, 1, 6);
    chk("t1_model", {24'd0, exp_data}, 32'h1C);
    chk("t1_data", {24'd0, io}, 32'h1C);
    chk("t1_valid_count", n_valid, 1);

    // 2: extended make then extended release
    vb = n_valid;
    send_frame(8'hE0, 0, 1, 5);
    send_frame(8'h75, 0, 1, 5);
    chk("t2_data", {24'd0, io}, 32'h75);
    chk("t2_ext", {31'd0, kext}, 32'h1);
    send_frame(8'hE0, 0, 1, 5);
    send_frame(8'hF0, 0, 1, 5);
    send_frame(8'h75, 0, 1, 5);
    chk("t2_release_data", {24'd0, io}, 32'h00);
    chk("t2_release_ext", {31'd0, kext}, 32'h0);
    chk("t2_valid_count", n_valid - vb, 1);

    // 3: release of a key that is no longer held
    send_frame(8'h1B, 0, 1, 4);
    send_frame(8'h1D, 0, 1, 4);
    send_frame(8'hF0, 0, 1, 4);
    send_frame(8'h1B, 0, 1, 4);
    chk("t3_data", {24'd0, io}, 32'h1D);

    // 4: bad parity, then bad stop bit
    ve = n_err;
    send_frame(8'h23, 1, 1, 5);
`ifdef PS2_PARITY_CHECK_EN
    chk("t4_parity_data", {24'd0, io}, 32'h1D);
    chk("t4_parity_err", n_err - ve, 1);
`else
    chk("t4_parity_data", {24'd0, io}, 32'h23);
    chk("t4_parity_err", n_err - ve, 0);
`endif
    ve = n_err;
    send_frame(8'h44, 0, 0, 5);
    chk("t4_stop_err", n_err - ve, 1);

    // 5: five bits then silence until the timeout
    ve = n_err;
    m_ext    = 1'b0;
    m_brk    = 1'b0;
    ev_data  = m_held;
    ev_ext   = m_kext;
    ev_valid = 1'b0;
    ev_err   = 1'b1;
    send_bit(1'b0, 5);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 5);
    arm_ofs = LAT + T;
    arm     = 1'b1;
    send_bit(1'b0, 5);
    repeat (T + 10) @(negedge clk);
    chk("t5_timeout_err", n_err - ve, 1);
    send_frame(8'h72, 0, 1, 5);
    chk("t5_data", {24'd0, io}, 32'h72);

    // 6: reset in the middle of an F0 frame whose remaining bits are all ones
    send_frame(8'h1C, 0, 1, 5);
    vb = n_valid;
    send_bit(1'b0, 5);
    for (int i = 0; i < 4; i++) send_bit(1'b0, 5);
    @(negedge clk);
    reset   = 1'b1;
    ev_data = 8'h00;
    ev_ext  = 1'b0;
    ev_valid = 1'b0;
    ev_err  = 1'b0;
    ev_cyc  = cyc + 1;
    m_held  = 8'h00;
    m_kext  = 1'b0;
    m_ext   = 1'b0;
    m_brk   = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("t6_reset_data", {24'd0, io}, 32'h00);
    for (int i = 0; i < 6; i++) send_bit(1'b1, 5);
    repeat (10) @(negedge clk);
    chk("t6_no_valid", n_valid - vb, 0);
    send_frame(8'h1B, 0, 1, 5);
    chk("t6_data", {24'd0, io}, 32'h1B);

    // randomized key stream with occasional corrupted frames
    for (int n = 0; n < 120; n++) begin
      r    = int'($urandom_range(0, 9));
      h    = int'($urandom_range(4, 10));
      code = 8'($urandom_range(1, 255));
      if (code == 8'hE0 || code == 8'hF0) code = code ^ 8'h01;
      if (r < 4) begin
        if ($urandom_range(0, 1) == 1) send_frame(8'hE0, 0, 1, h);
        send_frame(code, 0, 1, h);
      end else if (r < 7) begin
        if ($urandom_range(0, 1) == 1) send_frame(8'hE0, 0, 1, h);
        send_frame(8'hF0, 0, 1, h);
        send_frame(($urandom_range(0, 2) != 0 && m_held != 8'h00) ? m_held : code, 0, 1, h);
      end else if (r == 7) begin
        send_frame(code, 1, 1, h);
      end else if (r == 8) begin
        send_frame(code, 0, 0, h);
      end else begin
        send_frame((m_held != 8'h00) ? m_held : code, 0, 1, h);
      end
    end
    repeat (20) @(negedge clk);
    checking = 1'b0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
